button_conditioner: RTL and testbench

//  Front-end stage for the clock/timer/stopwatch core: conditions NUM_BTN raw push-buttons
//  (bit0 load_counter, bit1 stop, bit2 start). Per button: 2-FF synchroniser, counter debounce,
//  one-cycle press/release pulses, auto-repeat pulse train while held. Outputs feed the

---
 rtl/clock_pkg.sv | 27 ++
 rtl/btn_channel.sv | 133 +++++++++++++
 rtl/button_conditioner.sv | 47 ++++
 tb/tb_button_conditioner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and types for the clock/timer/stopwatch front end.
package clock_pkg;

    localparam int unsigned CLK_HZ = 100000000;

    // Default timing: 10 ms debounce, 0.5 s to first repeat, 0.2 s between repeats.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int unsigned DEF_REPEAT_DELAY    = CLK_HZ / 2;
    localparam int unsigned DEF_REPEAT_PERIOD   = CLK_HZ / 5;

    // Button channel indices as wired to the core.
    localparam int unsigned BTN_LOAD  = 0;
    localparam int unsigned BTN_STOP  = 1;
    localparam int unsigned BTN_START = 2;

    // Auto-repeat state per channel.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rp_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, counter debounce, press/release
// pulses and an auto-repeat pulse train while the button stays held.
module btn_channel
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      btn_raw,
    output logic      btn_level,
    output logic      btn_press,
    output logic      btn_release,
    output logic      btn_repeat,
    output rp_state_e rp_state
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RP_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            press_q;
    logic            release_q;
    logic            repeat_q;
    logic [RP_W-1:0] rp_cnt_q;
    rp_state_e       state_q;
    logic            rise;
    logic            fall;

    // Debounce: the synced input must disagree with the stable state for
    // DEBOUNCE_CYCLES consecutive cycles before the stable state follows it.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Edge of the debounced level, seen one cycle early so pulses land on
    // the same edge as the level change.
    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    // Synchroniser, debounce state and registered press/release pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= rise;
            release_q <= fall;
        end
    end

    // Auto-repeat FSM; a debounced fall always returns to IDLE without a
    // pulse, even when it coincides with a terminal count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            rp_cnt_q <= '0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            if (fall) begin
                state_q  <= IDLE;
                rp_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            repeat_q <= 1'b1;
                            rp_cnt_q <= '0;
                            state_q  <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (rp_cnt_q == RD_LAST) begin
                            repeat_q <= 1'b1;
                            rp_cnt_q <= '0;
                            state_q  <= REPEAT;
                        end else begin
                            rp_cnt_q <= rp_cnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rp_cnt_q == RP_LAST) begin
                            repeat_q <= 1'b1;
                            rp_cnt_q <= '0;
                        end else begin
                            rp_cnt_q <= rp_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        rp_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_level   = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;
    assign rp_state    = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw push-buttons (load_counter, stop, start) into
// debounced levels, press/release pulses and auto-repeat pulses.
module button_conditioner
    import clock_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output rp_state_e          dbg_rp_state [NUM_BTN]
);

    // A counter shorter than 2 cannot separate adjacent pulses.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_PERIOD < 2) begin : g_bad_period
        $error("button_conditioner: REPEAT_PERIOD must be at least 2");
    end

    // One independent channel per button.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_repeat (btn_repeat[i]),
            .rp_state   (dbg_rp_state[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short sim timing (debounce 4, repeat 10/3).
module tb_button_conditioner;
  import clock_pkg::*;

  localparam int NB = 3;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
  rp_state_e     dbg_state [NB];

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat),
    .dbg_rp_state(dbg_state)
  );

  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else begin
      fail_cnt++;
      if (fail_cnt <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Level flips once the last DC synced samples all disagree with it; repeat
  // pulses fall at press age 0, RD, RD+RP, RD+2*RP, ... while the level holds.
  logic [NB-1:0] m_d1 = '0, m_d2 = '0;
  logic [NB-1:0] m_level = '0, m_press = '0, m_release = '0, m_repeat = '0;
  logic [DC-1:0] m_win [NB];
  int            m_win_n [NB];
  int            m_age [NB];
  rp_state_e     m_state [NB];

  initial begin
    for (int c = 0; c < NB; c++) begin
      m_win[c] = '0; m_win_n[c] = 0; m_age[c] = -1; m_state[c] = IDLE;
    end
  end

  always @(posedge clk) begin
    logic old_lvl;
    logic all_diff;
    if (!rst) begin
      m_d1 = '0; m_d2 = '0; m_level = '0;
      m_press = '0; m_release = '0; m_repeat = '0;
      for (int c = 0; c < NB; c++) begin
        m_win[c] = '0; m_win_n[c] = 0; m_age[c] = -1; m_state[c] = IDLE;
      end
    end else begin
      for (int c = 0; c < NB; c++) begin
        m_win[c] = {m_win[c][DC-2:0], m_d2[c]};
        if (m_win_n[c] < DC) m_win_n[c]++;
        old_lvl = m_level[c];
        all_diff = (m_win_n[c] == DC) && (m_win[c] == (old_lvl ? {DC{1'b0}} : {DC{1'b1}}));
        if (all_diff) m_level[c] = ~old_lvl;
        m_press[c]   = m_level[c] & ~old_lvl;
        m_release[c] = ~m_level[c] & old_lvl;
        if (!m_level[c]) m_age[c] = -1;
        else if (!old_lvl) m_age[c] = 0;
        else m_age[c] = m_age[c] + 1;
        m_repeat[c] = m_level[c] && (m_age[c] == 0 || m_age[c] == RD ||
                      (m_age[c] > RD && ((m_age[c] - RD) % RP) == 0));
        m_state[c] = !m_level[c] ? IDLE : (m_age[c] < RD ? DELAY : REPEAT);
      end
      m_d2 = m_d1;
      m_d1 = btn_raw;
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    chk("level",   8'(btn_level),   8'(m_level));
    chk("press",   8'(btn_press),   8'(m_press));
    chk("release", 8'(btn_release), 8'(m_release));
    chk("repeat",  8'(btn_repeat),  8'(m_repeat));
    for (int c = 0; c < NB; c++)
      chk($sformatf("state%0d", c), 8'(dbg_state[c]), 8'(m_state[c]));
  end

  // Pulse counters for directed checks.
  int press_n [NB];
  int release_n [NB];
  int repeat_n [NB];
  initial for (int c = 0; c < NB; c++) begin press_n[c] = 0; release_n[c] = 0; repeat_n[c] = 0; end
  always @(negedge clk) begin
    for (int c = 0; c < NB; c++) begin
      press_n[c]   += int'(btn_press[c]);
      release_n[c] += int'(btn_release[c]);
      repeat_n[c]  += int'(btn_repeat[c]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    btn_raw = '0;
    wait_neg(n);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int p0, r0, q0;
    int hold [NB];

    // 1: reset with all buttons held, then release reset
    rst = 1'b0; btn_raw = 3'b111;
    wait_neg(5);
    chk("t1_rst_level", 8'(btn_level), 8'h0);
    chk("t1_rst_pulses", 8'(btn_press | btn_release | btn_repeat), 8'h0);
    rst = 1'b1;
    wait_neg(5);
    chk("t1_level_at5", 8'(btn_level), 8'h0);
    wait_neg(1);
    chk("t1_level_at6", 8'(btn_level), 8'h7);
    chk("t1_press_at6", 8'(btn_press), 8'h7);
    chk("t1_repeat_at6", 8'(btn_repeat), 8'h7);
    idle(15);

    // 2: clean press on channel 0 held 30 clocks
    btn_raw[BTN_LOAD] = 1'b1;
    wait_neg(5);
    chk("t2_level_at5", 8'(btn_level), 8'h0);
    wait_neg(1);
    chk("t2_press_at6", 8'(btn_press), 8'h1);
    chk("t2_repeat_at6", 8'(btn_repeat), 8'h1);
    chk("t2_model_press_at6", 8'(m_press), 8'h1);
    wait_neg(1);
    chk("t2_press_at7", 8'(btn_press), 8'h0);
    chk("t2_repeat_at7", 8'(btn_repeat), 8'h0);
    wait_neg(8);
    chk("t2_repeat_at15", 8'(btn_repeat), 8'h0);
    wait_neg(1);
    chk("t2_repeat_at16", 8'(btn_repeat), 8'h1);
    chk("t2_model_repeat_at16", 8'(m_repeat), 8'h1);
    wait_neg(2);
    chk("t2_repeat_at18", 8'(btn_repeat), 8'h0);
    wait_neg(1);
    chk("t2_repeat_at19", 8'(btn_repeat), 8'h1);
    wait_neg(11);
    btn_raw[BTN_LOAD] = 1'b0;
    wait_neg(5);
    chk("t2_release_at5", 8'(btn_release), 8'h0);
    chk("t2_level_held", 8'(btn_level), 8'h1);
    wait_neg(1);
    chk("t2_release_at6", 8'(btn_release), 8'h1);
    chk("t2_level_low", 8'(btn_level), 8'h0);
    idle(15);

    // 3: channel 1 bouncing every 2 clocks never debounces
    p0 = press_n[BTN_STOP]; r0 = release_n[BTN_STOP]; q0 = repeat_n[BTN_STOP];
    for (int i = 0; i < 20; i++) begin
      btn_raw[BTN_STOP] = ((i / 2) % 2) == 0;
      wait_neg(1);
    end
    idle(10);
    chk("t3_level", 8'(btn_level[BTN_STOP]), 8'h0);
    chk("t3_no_pulses", 8'(press_n[BTN_STOP] - p0 + release_n[BTN_STOP] - r0 + repeat_n[BTN_STOP] - q0), 8'h0);

    // 4: 3-clock glitch ignored, then a held press gives exactly one press
    p0 = press_n[BTN_START];
    btn_raw[BTN_START] = 1'b1;
    wait_neg(3);
    idle(10);
    chk("t4_glitch_press", 8'(press_n[BTN_START] - p0), 8'h0);
    btn_raw[BTN_START] = 1'b1;
    wait_neg(12);
    chk("t4_one_press", 8'(press_n[BTN_START] - p0), 8'h1);
    idle(12);
    chk("t4_one_release", 8'(btn_level[BTN_START]), 8'h0);

    // 5: release lands on a REPEAT terminal count (press+16)
    btn_raw[BTN_LOAD] = 1'b1;
    wait_neg(16);
    btn_raw[BTN_LOAD] = 1'b0;
    wait_neg(3);
    chk("t5_repeat_at19", 8'(btn_repeat), 8'h1);
    wait_neg(3);
    chk("t5_release", 8'(btn_release), 8'h1);
    chk("t5_no_repeat", 8'(btn_repeat), 8'h0);
    chk("t5_state_idle", 8'(dbg_state[BTN_LOAD]), 8'(IDLE));
    idle(10);

    // 6: reset while held in REPEAT, then release reset still held
    btn_raw[BTN_LOAD] = 1'b1;
    wait_neg(20);
    chk("t6_state_repeat", 8'(dbg_state[BTN_LOAD]), 8'(REPEAT));
    r0 = release_n[BTN_LOAD];
    rst = 1'b0;
    wait_neg(1);
    chk("t6_rst_outputs", 8'(btn_level | btn_press | btn_release | btn_repeat), 8'h0);
    chk("t6_rst_state", 8'(dbg_state[BTN_LOAD]), 8'(IDLE));
    rst = 1'b1;
    wait_neg(5);
    chk("t6_level_at5", 8'(btn_level), 8'h0);
    wait_neg(1);
    chk("t6_press_at6", 8'(btn_press), 8'h1);
    chk("t6_repeat_at6", 8'(btn_repeat), 8'h1);
    chk("t6_no_release", 8'(release_n[BTN_LOAD] - r0), 8'h0);
    idle(15);

    // Random phase: mix of short bounces and long holds, rare resets.
    for (int c = 0; c < NB; c++) hold[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          hold[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(5, 40));
        end
        hold[c]--;
      end
      rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      wait_neg(1);
    end
    rst = 1'b1;
    idle(20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
